onehot_regfile: RTL and testbench

- 16-entry register file that consumes the 16-bit one-hot write-enable vector produced by the team's 4-to-16 decoder stage.
- Sits directly downstream of that decoder: the decoder's en/s pair selects the destination register, and this block performs the write.
- Provides two registered read ports.
- Provides a hardware clear sequencer that zeroes all 16 entries, one per cycle.
- Flags illegal (multi-hot) enable vectors and writes dropped while busy.

---
 rtl/onehot_regfile_pkg.sv | 18 +
 rtl/onehot_check.sv | 29 ++
 rtl/onehot_regfile.sv | 109 ++++++++++
 tb/tb_onehot_regfile.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/onehot_regfile_pkg.sv
// Shared constants and types for the one-hot register file slice.
// Entry count is tied to the upstream 4-to-16 decoder width.
package regfile_pkg;

  localparam int NREGS  = 16;
  localparam int IDX_W  = 4;
  localparam int DATA_W = 16;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_CLEAR = 1'b1;

  // Resolved write port select: user write or clear-sweep write.
  typedef struct packed {
    logic             en;
    logic [IDX_W-1:0] addr;
  } wr_sel_t;

endpackage

// File: rtl/onehot_check.sv
// Classifies a decoder enable vector as none / exactly-one / multi-hot
// and encodes the index of the single set bit.
module onehot_check
  import regfile_pkg::*;
(
  input  logic [NREGS-1:0] we_onehot,
  output logic             valid_one,
  output logic             multi,
  output logic [IDX_W-1:0] idx
);

  logic any_set;
  logic pow2;

  assign any_set = (we_onehot != '0);
  // Clearing the lowest set bit leaves zero only for a single-bit vector.
  assign pow2    = ((we_onehot & (we_onehot - NREGS'(1))) == '0);

  assign valid_one = any_set && pow2;
  assign multi     = any_set && !pow2;

  always_comb begin
    idx = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (we_onehot[i]) idx = idx | IDX_W'(i);
    end
  end

endmodule

// File: rtl/onehot_regfile.sv
// 16-entry register file written by a one-hot enable, with two registered
// write-first read ports and a one-entry-per-cycle clear sweep.
module onehot_regfile #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       we_onehot,
  input  logic [DATA_W-1:0] w_data,
  input  logic [3:0]        r_addr_a,
  input  logic [3:0]        r_addr_b,
  output logic [DATA_W-1:0] r_data_a,
  output logic [DATA_W-1:0] r_data_b,
  input  logic              clr_req,
  output logic              busy,
  output logic              err_multi,
  output logic              err_drop
);

  import regfile_pkg::IDX_W;
  import regfile_pkg::ST_IDLE;
  import regfile_pkg::ST_CLEAR;
  import regfile_pkg::wr_sel_t;

  logic                           st;
  logic [IDX_W-1:0]               cidx;
  logic [NREGS-1:0][DATA_W-1:0]   mem;

  logic                           oh_valid;
  logic                           oh_multi;
  logic [IDX_W-1:0]               oh_idx;

  logic                           user_wr;
  logic                           clr_wr;
  wr_sel_t                        wr;
  logic [DATA_W-1:0]              wr_data;

  onehot_check u_check (
    .we_onehot (we_onehot),
    .valid_one (oh_valid),
    .multi     (oh_multi),
    .idx       (oh_idx)
  );

  // User writes only land while idle; the sweep owns the write port otherwise.
  assign user_wr = oh_valid && (st == ST_IDLE);
  assign clr_wr  = (st == ST_CLEAR);

  always_comb begin
    wr.en   = user_wr || clr_wr;
    wr.addr = clr_wr ? cidx : oh_idx;
    wr_data = clr_wr ? '0 : w_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wr.en && (wr.addr == IDX_W'(i))) mem[i] <= wr_data;
      end
    end
  end

  // Write-first: a write committing on the same edge is forwarded to the port.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data_a <= '0;
      r_data_b <= '0;
    end else begin
      r_data_a <= (wr.en && (wr.addr == r_addr_a)) ? wr_data : mem[r_addr_a];
      r_data_b <= (wr.en && (wr.addr == r_addr_b)) ? wr_data : mem[r_addr_b];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st   <= ST_IDLE;
      cidx <= '0;
    end else begin
      case (st)
        ST_IDLE: begin
          if (clr_req) begin
            st   <= ST_CLEAR;
            cidx <= '0;
          end
        end
        default: begin
          cidx <= cidx + IDX_W'(1);
          if (cidx == IDX_W'(NREGS - 1)) st <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (st == ST_CLEAR);

  always_ff @(posedge clk) begin
    if (reset) begin
      err_multi <= 1'b0;
      err_drop  <= 1'b0;
    end else begin
      if (oh_multi) err_multi <= 1'b1;
      if (oh_valid && (st == ST_CLEAR)) err_drop <= 1'b1;
    end
  end

endmodule

// File: tb/tb_onehot_regfile.sv
// Bench for onehot_regfile: directed scenarios plus randomized traffic
// against an array/countdown reference model.
module tb_onehot_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] we_onehot;
  logic [15:0] w_data;
  logic [3:0]  r_addr_a;
  logic [3:0]  r_addr_b;
  logic [15:0] r_data_a;
  logic [15:0] r_data_b;
  logic        clr_req;
  logic        busy;
  logic        err_multi;
  logic        err_drop;

  onehot_regfile dut (
    .clk       (clk),
    .reset     (reset),
    .we_onehot (we_onehot),
    .w_data    (w_data),
    .r_addr_a  (r_addr_a),
    .r_addr_b  (r_addr_b),
    .r_data_a  (r_data_a),
    .r_data_b  (r_data_b),
    .clr_req   (clr_req),
    .busy      (busy),
    .err_multi (err_multi),
    .err_drop  (err_drop)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;

  // Reference model: plain array, a countdown of remaining sweep entries.
  logic [15:0] m_mem [16];
  int          m_left;
  bit          m_multi;
  bit          m_drop;
  logic [15:0] exp_a;
  logic [15:0] exp_b;

  task automatic tick();
    int cnt;
    logic [3:0] ra;
    logic [3:0] rb;
    cnt = $countones(we_onehot);
    ra  = r_addr_a;
    rb  = r_addr_b;
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 16; i++) m_mem[i] = 16'h0000;
      m_left  = 0;
      m_multi = 0;
      m_drop  = 0;
    end else begin
      if (cnt >= 2) m_multi = 1;
      if (m_left > 0) begin
        if (cnt == 1) m_drop = 1;
        m_mem[16 - m_left] = 16'h0000;
        m_left--;
      end else begin
        if (cnt == 1)
          for (int i = 0; i < 16; i++) if (we_onehot[i]) m_mem[i] = w_data;
        if (clr_req) m_left = 16;
      end
    end
    exp_a = reset ? 16'h0000 : m_mem[ra];
    exp_b = reset ? 16'h0000 : m_mem[rb];
    #1;
  endtask

  task automatic test_reset();
    reset = 1; we_onehot = 0; w_data = 0; r_addr_a = 0; r_addr_b = 0; clr_req = 0;
    tick(); tick();
    reset = 0;
    n_cmp++;
    if ({busy, err_multi, err_drop, r_data_a, r_data_b} !== 35'd0) begin
      n_bad++;
      $display("FAIL reset_state: busy=%b em=%b ed=%b a=%h b=%h, want all 0",
               busy, err_multi, err_drop, r_data_a, r_data_b);
    end
    for (int i = 0; i < 16; i++) begin
      r_addr_a = 4'(i); r_addr_b = 4'(15 - i);
      tick();
      n_cmp++;
      if (r_data_a !== 16'h0000 || r_data_b !== 16'h0000) begin
        n_bad++;
        $display("FAIL reset_regs[%0d]: a=%h b=%h, want 0", i, r_data_a, r_data_b);
      end
    end
  endtask

  task automatic test_write_read();
    we_onehot = 16'h0008; w_data = 16'hA5A5;
    tick();
    we_onehot = 0; r_addr_a = 3; r_addr_b = 3;
    tick();
    n_cmp++;
    if (r_data_a !== 16'hA5A5 || r_data_b !== 16'hA5A5) begin
      n_bad++;
      $display("FAIL write_read3: a=%h b=%h, want a5a5", r_data_a, r_data_b);
    end
    for (int i = 0; i < 16; i++) begin
      if (i == 3) continue;
      r_addr_a = 4'(i); r_addr_b = 4'(i);
      tick();
      n_cmp++;
      if (r_data_a !== 16'h0000 || r_data_b !== exp_b) begin
        n_bad++;
        $display("FAIL write_read_other[%0d]: a=%h b=%h, want 0", i, r_data_a, r_data_b);
      end
    end
  endtask

  task automatic test_multi();
    we_onehot = 16'h0011; w_data = 16'hFFFF;
    tick();
    n_cmp++;
    if (err_multi !== 1'b1 || err_drop !== 1'b0) begin
      n_bad++;
      $display("FAIL multi_flag: em=%b ed=%b, want 1 0", err_multi, err_drop);
    end
    we_onehot = 0; r_addr_a = 0; r_addr_b = 4;
    tick();
    n_cmp++;
    if (r_data_a !== 16'h0000 || r_data_b !== 16'h0000) begin
      n_bad++;
      $display("FAIL multi_nowrite: r0=%h r4=%h, want 0 0", r_data_a, r_data_b);
    end
    for (int i = 0; i < 4; i++) begin
      we_onehot = 16'h0001 << (i + 10); w_data = 16'(16'h1111 * (i + 1));
      tick();
      n_cmp++;
      if (err_multi !== 1'b1) begin
        n_bad++;
        $display("FAIL multi_sticky[%0d]: em=%b, want 1", i, err_multi);
      end
    end
    we_onehot = 0; reset = 1;
    tick();
    reset = 0;
    n_cmp++;
    if (err_multi !== 1'b0) begin
      n_bad++;
      $display("FAIL multi_reset: em=%b, want 0", err_multi);
    end
  endtask

  task automatic test_bypass();
    we_onehot = 16'h0080; w_data = 16'h0BAD;
    tick();
    we_onehot = 16'h0080; w_data = 16'h1234; r_addr_a = 7; r_addr_b = 7;
    tick();
    we_onehot = 0;
    n_cmp++;
    if (r_data_a !== 16'h1234 || r_data_b !== exp_b) begin
      n_bad++;
      $display("FAIL bypass: a=%h b=%h, want 1234", r_data_a, r_data_b);
    end
  endtask

  task automatic test_clear();
    int cnt;
    for (int i = 0; i < 16; i++) begin
      we_onehot = 16'h0001 << i; w_data = 16'hFFFF;
      tick();
    end
    we_onehot = 0; clr_req = 1;
    tick();
    clr_req = 0; cnt = 0; r_addr_a = 2; r_addr_b = 5;
    for (int k = 0; k < 40 && busy; k++) begin
      cnt++;
      if (cnt == 3) begin we_onehot = 16'h0004; w_data = 16'h5555; end
      else we_onehot = 0;
      tick();
      n_cmp++;
      if (busy !== (m_left > 0) || r_data_a !== exp_a || r_data_b !== exp_b) begin
        n_bad++;
        $display("FAIL clear_step[%0d]: busy=%b a=%h b=%h, want %b %h %h",
                 cnt, busy, r_data_a, r_data_b, m_left > 0, exp_a, exp_b);
      end
    end
    n_cmp++;
    if (cnt != 16) begin
      n_bad++;
      $display("FAIL clear_len: busy cycles=%0d, want 16", cnt);
    end
    n_cmp++;
    if (err_drop !== 1'b1) begin
      n_bad++;
      $display("FAIL clear_drop: ed=%b, want 1", err_drop);
    end
    r_addr_a = 5; r_addr_b = 2;
    tick();
    n_cmp++;
    if (r_data_a !== 16'h0000 || r_data_b !== 16'h0000) begin
      n_bad++;
      $display("FAIL clear_result: r5=%h r2=%h, want 0 0", r_data_a, r_data_b);
    end
  endtask

  task automatic test_clr_ignore();
    int cnt;
    clr_req = 1;
    tick();
    clr_req = 0; cnt = 0;
    for (int k = 0; k < 40 && busy; k++) begin
      cnt++;
      clr_req = (cnt == 10);
      tick();
    end
    clr_req = 0;
    n_cmp++;
    if (cnt != 16 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL clr_ignore: busy cycles=%0d busy=%b, want 16 0", cnt, busy);
    end
  endtask

  task automatic test_reset_abort();
    we_onehot = 16'h0011; tick(); we_onehot = 0;
    clr_req = 1; tick(); clr_req = 0;
    for (int k = 0; k < 5; k++) tick();
    reset = 1;
    tick();
    reset = 0;
    n_cmp++;
    if (busy !== 1'b0 || err_multi !== 1'b0 || err_drop !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_state: busy=%b em=%b ed=%b, want 0 0 0", busy, err_multi, err_drop);
    end
    we_onehot = 16'h0200; w_data = 16'h00C3;
    tick();
    we_onehot = 0; r_addr_a = 9; r_addr_b = 8;
    tick();
    n_cmp++;
    if (r_data_a !== 16'h00C3 || r_data_b !== 16'h0000 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_write: r9=%h r8=%h busy=%b, want 00c3 0000 0", r_data_a, r_data_b, busy);
    end
    for (int i = 0; i < 16; i++) begin
      r_addr_a = 4'(i);
      tick();
      n_cmp++;
      if (r_data_a !== ((i == 9) ? 16'h00C3 : 16'h0000)) begin
        n_bad++;
        $display("FAIL abort_regs[%0d]: %h", i, r_data_a);
      end
    end
  endtask

  task automatic test_random();
    int sel;
    int b0;
    int b1;
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 9);
      b0  = $urandom_range(0, 15);
      b1  = (b0 + $urandom_range(1, 15)) % 16;
      if (sel < 7)       we_onehot = 16'h0001 << b0;
      else if (sel == 7) we_onehot = 16'h0000;
      else if (sel == 8) we_onehot = (16'h0001 << b0) | (16'h0001 << b1);
      else               we_onehot = 16'($urandom);
      w_data   = 16'($urandom);
      r_addr_a = 4'($urandom);
      r_addr_b = ($urandom_range(0, 3) == 0) ? r_addr_a : 4'($urandom);
      clr_req  = ($urandom_range(0, 29) == 0);
      tick();
      n_cmp++;
      if (r_data_a !== exp_a || r_data_b !== exp_b || busy !== (m_left > 0) ||
          err_multi !== m_multi || err_drop !== m_drop) begin
        n_bad++;
        $display("FAIL random[%0d]: a=%h b=%h busy=%b em=%b ed=%b, want %h %h %b %b %b",
                 n, r_data_a, r_data_b, busy, err_multi, err_drop,
                 exp_a, exp_b, m_left > 0, m_multi, m_drop);
      end
    end
    clr_req = 0; we_onehot = 0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_multi();
    test_bypass();
    test_clear();
    test_clr_ignore();
    test_reset_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
